// File: rtl/data_transfer_pkg.sv
// rtl/data_transfer_pkg.sv - shared op/state enums and default sizes for data_transfer_ctrl
package data_transfer_pkg;

   localparam int DEF_DW       = 8;
   localparam int DEF_FR_DEPTH = 32;
   localparam int DEF_NREG     = 4;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_MOVE  = 2'b10,
      OP_SWAP  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_XFER,
      ST_SW1,
      ST_SW2,
      ST_SW3,
      ST_DONE
   } state_e;

endpackage

// File: rtl/dt_reg_file.sv
// rtl/dt_reg_file.sv - register file, async read, internal write has priority over external
module dt_reg_file #(
   parameter int DW       = 8,
   parameter int FR_DEPTH = 32,
   parameter int AW       = $clog2(FR_DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   input  logic          int_we,
   input  logic [AW-1:0] int_addr,
   input  logic [DW-1:0] int_data,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_data
);

   logic [DW-1:0] mem [FR_DEPTH];

   // Reads see the pre-edge contents, so a same-cycle write is never forwarded.
   assign rd_data = mem[rd_addr];

   // A single write per cycle; a command store silently drops a colliding external write.
   always_ff @(posedge clk) begin
      if (int_we)
         mem[int_addr] <= int_data;
      else if (ext_we)
         mem[ext_addr] <= ext_data;
   end

endmodule

// File: rtl/data_transfer_ctrl.sv
// rtl/data_transfer_ctrl.sv - transfer FSM, working registers and muxed bus; DT_SWAP_EN builds SWAP
module data_transfer_ctrl
   import data_transfer_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int FR_DEPTH = DEF_FR_DEPTH,
   parameter int NREG     = DEF_NREG,
   localparam int AW      = $clog2(FR_DEPTH),
   localparam int RW      = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          FR_W,
   input  logic [AW-1:0] FR_WADDR,
   input  logic [DW-1:0] FR_WDATA,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_src,
   input  logic [AW-1:0] cmd_dst,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] bus,
   input  logic [RW-1:0] rd_sel,
   output logic [DW-1:0] rd_data
);

   state_e        state, state_n;
   op_e           op_q;
   logic [AW-1:0] src_q, dst_q;
   logic          illegal_q;
   logic          src_bad, dst_bad, cmd_illegal;
   logic [DW-1:0] regs [NREG];
   logic [DW-1:0] file_rdata, reg_src, reg_dst;
   logic [RW-1:0] src_sel, dst_sel, reg_wsel;
   logic          reg_we, file_we;
`ifdef DT_SWAP_EN
   logic [DW-1:0] tmp;
   logic          tmp_we;
`endif

   assign src_sel = src_q[RW-1:0];
   assign dst_sel = dst_q[RW-1:0];
   assign reg_src = regs[src_sel];
   assign reg_dst = regs[dst_sel];
   assign rd_data = (32'(rd_sel) < NREG) ? regs[rd_sel] : '0;
   assign src_bad = 32'(cmd_src) >= NREG;
   assign dst_bad = 32'(cmd_dst) >= NREG;

   // Legality is judged only on the fields that actually index a working register.
   always_comb begin
      cmd_illegal = 1'b0;
      case (cmd_op)
         OP_LOAD:  cmd_illegal = dst_bad;
         OP_STORE: cmd_illegal = src_bad;
         OP_MOVE:  cmd_illegal = src_bad | dst_bad;
`ifdef DT_SWAP_EN
         default:  cmd_illegal = src_bad | dst_bad;
`else
         default:  cmd_illegal = 1'b1;
`endif
      endcase
   end

   dt_reg_file #(.DW(DW), .FR_DEPTH(FR_DEPTH), .AW(AW)) u_file (
      .clk      (clk),
      .rd_addr  (src_q),
      .rd_data  (file_rdata),
      .int_we   (file_we & ~rst),
      .int_addr (dst_q),
      .int_data (bus),
      .ext_we   (FR_W),
      .ext_addr (FR_WADDR),
      .ext_data (FR_WDATA)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Next state, bus driver selection and write strobes; illegal commands never write.
   always_comb begin
      state_n   = state;
      cmd_ready = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      bus       = '0;
      reg_we    = 1'b0;
      reg_wsel  = dst_sel;
      file_we   = 1'b0;
`ifdef DT_SWAP_EN
      tmp_we    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_n = ST_XFER;
`ifdef DT_SWAP_EN
               if (cmd_op == OP_SWAP && !cmd_illegal) state_n = ST_SW1;
`endif
            end
         end
         ST_XFER: begin
            state_n = ST_DONE;
            if (!illegal_q) begin
               case (op_q)
                  OP_LOAD:  begin bus = file_rdata; reg_we = 1'b1; end
                  OP_STORE: begin bus = reg_src;    file_we = 1'b1; end
                  OP_MOVE:  begin bus = reg_src;    reg_we = 1'b1; end
                  default:  ;
               endcase
            end
         end
`ifdef DT_SWAP_EN
         ST_SW1: begin
            bus     = reg_src;
            tmp_we  = 1'b1;
            state_n = ST_SW2;
         end
         ST_SW2: begin
            bus      = reg_dst;
            reg_we   = 1'b1;
            reg_wsel = src_sel;
            state_n  = ST_SW3;
         end
         ST_SW3: begin
            bus     = tmp;
            reg_we  = 1'b1;
            state_n = ST_DONE;
         end
`endif
         ST_DONE: begin
            done    = ~illegal_q;
            err     = illegal_q;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Command capture and working-register updates from the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         op_q      <= OP_LOAD;
         src_q     <= '0;
         dst_q     <= '0;
         illegal_q <= 1'b0;
`ifdef DT_SWAP_EN
         tmp       <= '0;
`endif
      end else begin
         if (cmd_valid && cmd_ready) begin
            op_q      <= op_e'(cmd_op);
            src_q     <= cmd_src;
            dst_q     <= cmd_dst;
            illegal_q <= cmd_illegal;
         end
         if (reg_we) regs[reg_wsel] <= bus;
`ifdef DT_SWAP_EN
         if (tmp_we) tmp <= bus;
`endif
      end
   end

endmodule

// File: tb/tb_data_transfer_ctrl.sv
// tb/tb_data_transfer_ctrl.sv - directed self-checking bench for data_transfer_ctrl
module tb_data_transfer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       FR_W;
   logic [4:0] FR_WADDR;
   logic [7:0] FR_WDATA;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [4:0] cmd_src;
   logic [4:0] cmd_dst;
   logic       done;
   logic       err;
   logic [7:0] bus;
   logic [1:0] rd_sel;
   logic [7:0] rd_data;

   int tests = 0;
   int fails = 0;

   data_transfer_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .FR_W      (FR_W),
      .FR_WADDR  (FR_WADDR),
      .FR_WDATA  (FR_WDATA),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .done      (done),
      .err       (err),
      .bus       (bus),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
      rd_sel = idx;
      #1;
      chk(tag, rd_data, exp);
   endtask

   task automatic file_write(input logic [4:0] a, input logic [7:0] d);
      FR_W = 1'b1; FR_WADDR = a; FR_WDATA = d;
      tick();
      FR_W = 1'b0;
   endtask

   // Presents one command in IDLE and leaves the DUT in its first post-accept cycle.
   task automatic issue(input logic [1:0] op, input logic [4:0] s, input logic [4:0] d);
      cmd_op = op; cmd_src = s; cmd_dst = d; cmd_valid = 1'b1;
      chk("ready_before_accept", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   // Full 3-cycle legal transfer with bus and done checks.
   task automatic run3(input string tag, input logic [1:0] op, input logic [4:0] s,
                       input logic [4:0] d, input logic [7:0] exp_bus);
      issue(op, s, d);
      chk({tag, "_bus"}, bus, exp_bus);
      chk({tag, "_ready_xfer"}, cmd_ready, 0);
      chk({tag, "_done_xfer"}, done, 0);
      tick();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_err"}, err, 0);
      tick();
   endtask

   initial begin
      rst = 1'b1; FR_W = 1'b0; FR_WADDR = '0; FR_WDATA = '0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; rd_sel = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_bus", bus, 0);
      for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'h00);

      file_write(5'd0, 8'h06);
      file_write(5'd1, 8'h05);

      run3("load0", 2'b00, 5'd0, 5'd0, 8'h06);
      chk_reg("load0_r0", 2'd0, 8'h06);
      run3("load1", 2'b00, 5'd1, 5'd1, 8'h05);
      chk_reg("load1_r1", 2'd1, 8'h05);

      // MOVE r1->r0 with cmd_valid held: second acceptance only three cycles later.
      cmd_op = 2'b10; cmd_src = 5'd1; cmd_dst = 5'd0; cmd_valid = 1'b1;
      tick();
      chk("mv_bus", bus, 8'h05);
      chk("mv_ready_c1", cmd_ready, 0);
      tick();
      chk("mv_ready_c2", cmd_ready, 0);
      chk("mv_done", done, 1);
      chk_reg("mv_r0", 2'd0, 8'h05);
      chk_reg("mv_r1", 2'd1, 8'h05);
      tick();
      chk("mv_ready_c3", cmd_ready, 1);
      chk("mv_done_c3", done, 0);
      tick();
      cmd_valid = 1'b0;
      chk("mv2_ready", cmd_ready, 0);
      chk("mv2_bus", bus, 8'h05);
      tick();
      chk("mv2_done", done, 1);
      tick();

      // STORE r0->file[7] colliding with an external write of 0xAA.
      issue(2'b01, 5'd0, 5'd7);
      FR_W = 1'b1; FR_WADDR = 5'd7; FR_WDATA = 8'hAA;
      chk("st_bus", bus, 8'h05);
      tick();
      FR_W = 1'b0;
      chk("st_done", done, 1);
      tick();
      run3("ld7", 2'b00, 5'd7, 5'd2, 8'h05);
      chk_reg("ld7_r2", 2'd2, 8'h05);

      // LOAD during an external write to the same address returns the old value.
      issue(2'b00, 5'd7, 5'd3);
      FR_W = 1'b1; FR_WADDR = 5'd7; FR_WDATA = 8'h77;
      chk("rbw_bus", bus, 8'h05);
      tick();
      FR_W = 1'b0;
      chk("rbw_done", done, 1);
      chk_reg("rbw_r3", 2'd3, 8'h05);
      tick();
      run3("ld7b", 2'b00, 5'd7, 5'd3, 8'h77);
      chk_reg("ld7b_r3", 2'd3, 8'h77);

      // Register index == NREG is rejected.
      issue(2'b10, 5'd4, 5'd0);
      chk("ill_bus", bus, 8'h00);
      tick();
      chk("ill_err", err, 1);
      chk("ill_done", done, 0);
      chk_reg("ill_r0", 2'd0, 8'h05);
      tick();
      chk("ill_ready", cmd_ready, 1);
      chk("ill_err_clr", err, 0);

`ifdef DT_SWAP_EN
      run3("ld0b", 2'b00, 5'd0, 5'd0, 8'h06);
      issue(2'b11, 5'd0, 5'd1);
      chk("sw1_bus", bus, 8'h06);
      tick();
      chk("sw2_bus", bus, 8'h05);
      tick();
      chk("sw3_bus", bus, 8'h06);
      chk("sw3_done", done, 0);
      tick();
      chk("sw_done", done, 1);
      chk_reg("sw_r0", 2'd0, 8'h05);
      chk_reg("sw_r1", 2'd1, 8'h06);
      tick();
      chk("sw_ready", cmd_ready, 1);
`else
      issue(2'b11, 5'd0, 5'd1);
      chk("op11_bus", bus, 8'h00);
      tick();
      chk("op11_err", err, 1);
      chk("op11_done", done, 0);
      chk_reg("op11_r0", 2'd0, 8'h05);
      chk_reg("op11_r1", 2'd1, 8'h05);
      tick();
`endif

      // Reset in the XFER cycle of a LOAD aborts it.
      issue(2'b00, 5'd0, 5'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ready", cmd_ready, 1);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      chk("abort_bus", bus, 0);
      for (int i = 0; i < 4; i++) chk_reg("abort_reg", 2'(i), 8'h00);
      tick();
      chk("abort_done_late", done, 0);

      // File contents survive reset.
      run3("post_rst_ld7", 2'b00, 5'd7, 5'd0, 8'h77);
      chk_reg("post_rst_r0", 2'd0, 8'h77);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
